qea_ctrl_loader: RTL and testbench

QEA_CTRL_LOADER -- requirements
Module: qea_ctrl_loader
Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-high; ports named clk and rst.
REQ-002 Parameter PE_NUM, default 4, SHALL set the number of PE lanes per state word.
REQ-003 Parameter DATA_WIDTH, default 32, SHALL set the real/imag width; one amplitude is 2*DATA_WIDTH bits, {real,imag}.
REQ-004 Parameter STATE_ADDR_WIDTH, default 16, SHALL set the state RAM address width.
REQ-005 Parameter GATE_CONTEXT_ADDR_WIDTH, default 16, SHALL set the context RAM address width; context word is 2*DATA_WIDTH bits.
REQ-006 Parameter MAX_QBIT_WIDTH, default 6, SHALL set the qubit-count width.
REQ-007 Parameter NUM_FRAC_BIT, default 30, SHALL set fixed-point fraction bits; 1.0 = 1<<NUM_FRAC_BIT.
REQ-008 Parameter CNT_WIDTH, default 32, SHALL set the execution cycle counter width.
REQ-009 clk  in  1  rising-edge clock.
REQ-010 rst  in  1  async active-high reset.
REQ-011 i_cfg_start  in  1  job start request, sampled in IDLE only.
REQ-012 i_qbit_num  in  MAX_QBIT_WIDTH  qubit count, latched at job start.
REQ-013 i_ins_num  in  GATE_CONTEXT_ADDR_WIDTH+1  context words to load, latched at job start.
REQ-014 i_ctx_valid  in  1  upstream context word valid.
REQ-015 o_ctx_ready  out  1  loader accepts context word.
REQ-016 i_ctx_data  in  2*DATA_WIDTH  upstream context word.
REQ-017 o_ctx_en / o_ctx_wea  out  1 each  context RAM enable / write enable to QEA.
REQ-018 o_ctx_addr  out  GATE_CONTEXT_ADDR_WIDTH  context RAM write address.
REQ-019 o_ctx_data  out  2*DATA_WIDTH  context RAM write data.
REQ-020 o_state_ena / o_state_wea  out  1 each  state RAM enable / write enable to QEA.
REQ-021 o_state_addra  out  STATE_ADDR_WIDTH  state RAM address.
REQ-022 o_state_dina  out  PE_NUM*2*DATA_WIDTH  state RAM write data.
REQ-023 o_qea_start  out  1  QEA start pulse.
REQ-024 i_qea_complete  in  1  QEA completion level.
REQ-025 o_busy  out  1  high in every state except IDLE.
REQ-026 o_done / o_err  out  1 each  one-cycle job-done / config-error pulses.
REQ-027 o_cycle_cnt  out  CNT_WIDTH  QEA execution cycles of last job.
Function
REQ-028 FSM states SHALL be IDLE, LOAD_CTX, INIT_STATE, START, WAIT, DONE; all outputs registered.
REQ-029 IDLE: on i_cfg_start, i_qbit_num<2 or >STATE_ADDR_WIDTH+2 SHALL pulse o_err next cycle and stay IDLE; else latch config, go LOAD_CTX (INIT_STATE if i_ins_num==0).
REQ-030 LOAD_CTX: o_ctx_ready=1; each valid&ready cycle SHALL produce, one cycle later, o_ctx_en=o_ctx_wea=1, o_ctx_addr=k (k=0,1,...), o_ctx_data=accepted word; no write on cycles without a transfer.
REQ-031 After the i_ins_num-th transfer o_ctx_ready SHALL drop the next cycle and FSM go INIT_STATE; o_ctx_ready=0 in all other states.
REQ-032 INIT_STATE: SHALL write N=2^(i_qbit_num-2) words, one per cycle, addresses 0..N-1, o_state_ena=o_state_wea=1.
REQ-033 Word 0 SHALL hold real=1<<NUM_FRAC_BIT in the top DATA_WIDTH bits of o_state_dina (lane PE_NUM-1), all other bits 0; words 1..N-1 SHALL be all zero.
REQ-034 START: o_qea_start=1 for exactly one cycle; o_cycle_cnt cleared to 0 in that cycle.
REQ-035 WAIT: o_cycle_cnt SHALL increment each cycle, saturating at all-ones; i_qea_complete ignored in the first WAIT cycle, then complete=1 SHALL move to DONE with the count frozen.
REQ-036 DONE: o_done=1 for one cycle, return IDLE; o_cycle_cnt held until next START.
REQ-037 i_cfg_start outside IDLE SHALL be ignored; i_ctx_valid outside LOAD_CTX SHALL not be consumed.
Reset
REQ-038 rst, at any time incl. mid-job, SHALL force IDLE and all outputs, counters and addresses to 0 asynchronously; no partial write after release.
Verification
REQ-039 qbit=4, ins=3, words A,B,C back-to-back -> ctx writes addr0=A,1=B,2=C on 3 consecutive cycles; state writes addr0..3, addr0 top word 0x40000000_00000000, rest 0.
REQ-040 ins=4 with i_ctx_valid toggling 1,0,1,0 -> exactly 4 writes, addresses 0..3 contiguous, no write on gap cycles.
REQ-041 complete asserted 10 cycles after o_qea_start -> o_cycle_cnt=10, o_done pulses once, o_busy falls with it.
REQ-042 i_cfg_start with qbit=1 and qbit=19 -> o_err one-cycle pulse each, no RAM writes, o_busy stays 0.
REQ-043 rst asserted during INIT_STATE at addr 5 -> all outputs 0 immediately; new job restarts ctx at addr 0.
REQ-044 ins=0, qbit=2 -> no ctx writes, one state write addr0, then start pulse.

---
 rtl/qea_ctrl_loader_if.sv | 11 +
 rtl/qea_ctrl_loader.sv | 164 ++++++++++++++++
 tb/tb_qea_ctrl_loader.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/qea_ctrl_loader_if.sv
// Upstream context-word stream into the QEA control loader.
interface qea_ctrl_loader_if #(
  parameter int DATA_WIDTH = 32
);
  logic                    valid;
  logic                    ready;
  logic [2*DATA_WIDTH-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/qea_ctrl_loader.sv
// QEA job loader: streams gate context into the context RAM, seeds the state RAM
// with |0...0>, kicks the QEA and measures its execution time.
module qea_ctrl_loader #(
  parameter int PE_NUM                  = 4,
  parameter int DATA_WIDTH              = 32,
  parameter int STATE_ADDR_WIDTH        = 16,
  parameter int GATE_CONTEXT_ADDR_WIDTH = 16,
  parameter int MAX_QBIT_WIDTH          = 6,
  parameter int NUM_FRAC_BIT            = 30,
  parameter int CNT_WIDTH               = 32
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 i_cfg_start,
  input  logic [MAX_QBIT_WIDTH-1:0]            i_qbit_num,
  input  logic [GATE_CONTEXT_ADDR_WIDTH:0]     i_ins_num,
  qea_ctrl_loader_if.slave                     ctx,
  output logic                                 o_ctx_en,
  output logic                                 o_ctx_wea,
  output logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   o_ctx_addr,
  output logic [2*DATA_WIDTH-1:0]              o_ctx_data,
  output logic                                 o_state_ena,
  output logic                                 o_state_wea,
  output logic [STATE_ADDR_WIDTH-1:0]          o_state_addra,
  output logic [PE_NUM*2*DATA_WIDTH-1:0]       o_state_dina,
  output logic                                 o_qea_start,
  input  logic                                 i_qea_complete,
  output logic                                 o_busy,
  output logic                                 o_done,
  output logic                                 o_err,
  output logic [CNT_WIDTH-1:0]                 o_cycle_cnt
);
  localparam int GW  = GATE_CONTEXT_ADDR_WIDTH;
  localparam int SW  = STATE_ADDR_WIDTH;
  localparam int MQW = MAX_QBIT_WIDTH;
  localparam int SWD = PE_NUM*2*DATA_WIDTH;
  localparam logic [DATA_WIDTH-1:0] ONE   = DATA_WIDTH'(1) << NUM_FRAC_BIT;
  localparam logic [SWD-1:0]        WORD0 = {ONE, {(SWD-DATA_WIDTH){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_CTX, S_INIT_STATE, S_START, S_WAIT, S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [MQW-1:0]      qbit_q, qbit_d;
  logic [GW:0]         ins_q, ins_d, xfer_q, xfer_d;
  logic                ctx_ready_q, ctx_ready_d, ctx_en_q, ctx_en_d;
  logic [GW-1:0]       ctx_addr_q, ctx_addr_d;
  logic [2*DATA_WIDTH-1:0] ctx_data_q, ctx_data_d;
  logic                st_ena_q, st_ena_d;
  logic [SW-1:0]       st_addr_q, st_addr_d;
  logic [SWD-1:0]      st_din_q, st_din_d;
  logic                start_q, start_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [SW:0]         st_words;
  logic                xfer;

  assign st_words = (SW+1)'(1) << (qbit_q - MQW'(2));
  assign xfer     = ctx.valid && ctx_ready_q;

  always_comb begin
    state_d    = state_q;
    qbit_d     = qbit_q;
    ins_d      = ins_q;
    xfer_d     = xfer_q;
    ctx_en_d   = 1'b0;
    ctx_addr_d = '0;
    ctx_data_d = '0;
    st_addr_d  = '0;
    err_d      = 1'b0;
    cnt_d      = cnt_q;
    case (state_q)
      S_IDLE: if (i_cfg_start) begin
        if (i_qbit_num < MQW'(2) || i_qbit_num > MQW'(SW+2)) begin
          err_d = 1'b1;
        end else begin
          qbit_d  = i_qbit_num;
          ins_d   = i_ins_num;
          xfer_d  = '0;
          state_d = (i_ins_num == '0) ? S_INIT_STATE : S_LOAD_CTX;
        end
      end
      S_LOAD_CTX: if (xfer) begin
        ctx_en_d   = 1'b1;
        ctx_addr_d = xfer_q[GW-1:0];
        ctx_data_d = ctx.data;
        xfer_d     = xfer_q + (GW+1)'(1);
        if (xfer_q == ins_q - (GW+1)'(1)) state_d = S_INIT_STATE;
      end
      S_INIT_STATE: begin
        if ({1'b0, st_addr_q} == st_words - (SW+1)'(1)) state_d = S_START;
        else st_addr_d = st_addr_q + SW'(1);
      end
      S_START: state_d = S_WAIT;
      S_WAIT: begin
        if (cnt_q != '1) cnt_d = cnt_q + CNT_WIDTH'(1);
        // count is still zero only in the first WAIT cycle, where completion is ignored
        if (cnt_q != '0 && i_qea_complete) state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    ctx_ready_d = (state_d == S_LOAD_CTX);
    st_ena_d    = (state_d == S_INIT_STATE);
    st_din_d    = (st_ena_d && st_addr_d == '0) ? WORD0 : '0;
    start_d     = (state_d == S_START);
    if (start_d) cnt_d = '0;
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      qbit_q      <= '0;
      ins_q       <= '0;
      xfer_q      <= '0;
      ctx_ready_q <= 1'b0;
      ctx_en_q    <= 1'b0;
      ctx_addr_q  <= '0;
      ctx_data_q  <= '0;
      st_ena_q    <= 1'b0;
      st_addr_q   <= '0;
      st_din_q    <= '0;
      start_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      qbit_q      <= qbit_d;
      ins_q       <= ins_d;
      xfer_q      <= xfer_d;
      ctx_ready_q <= ctx_ready_d;
      ctx_en_q    <= ctx_en_d;
      ctx_addr_q  <= ctx_addr_d;
      ctx_data_q  <= ctx_data_d;
      st_ena_q    <= st_ena_d;
      st_addr_q   <= st_addr_d;
      st_din_q    <= st_din_d;
      start_q     <= start_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign ctx.ready     = ctx_ready_q;
  assign o_ctx_en      = ctx_en_q;
  assign o_ctx_wea     = ctx_en_q;
  assign o_ctx_addr    = ctx_addr_q;
  assign o_ctx_data    = ctx_data_q;
  assign o_state_ena   = st_ena_q;
  assign o_state_wea   = st_ena_q;
  assign o_state_addra = st_addr_q;
  assign o_state_dina  = st_din_q;
  assign o_qea_start   = start_q;
  assign o_busy        = busy_q;
  assign o_done        = done_q;
  assign o_err         = err_q;
  assign o_cycle_cnt   = cnt_q;
endmodule

// File: tb/tb_qea_ctrl_loader.sv
// Scoreboard bench for qea_ctrl_loader: stimulus pushes expectations, a negedge
// monitor pops and compares whenever the loader presents an output.
module tb_qea_ctrl_loader;
  localparam int PE = 4, DW = 32, SAW = 16, GW = 16, MQW = 6, NFB = 30, CW = 32;
  localparam int SWD = PE*2*DW;
  localparam logic [DW-1:0]  ONE   = DW'(1) << NFB;
  localparam logic [SWD-1:0] WORD0 = {ONE, {(SWD-DW){1'b0}}};

  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  logic           cfg_start = 1'b0, qea_complete = 1'b0;
  logic [MQW-1:0] qbit_num = '0;
  logic [GW:0]    ins_num = '0;
  logic           ctx_en, ctx_wea, state_ena, state_wea, qea_start, busy, done, err;
  logic [GW-1:0]  ctx_addr;
  logic [2*DW-1:0] ctx_data;
  logic [SAW-1:0] state_addra;
  logic [SWD-1:0] state_dina;
  logic [CW-1:0]  cycle_cnt;

  qea_ctrl_loader_if #(.DATA_WIDTH(DW)) ctx_if ();

  qea_ctrl_loader dut (
    .clk(clk), .rst(rst), .i_cfg_start(cfg_start), .i_qbit_num(qbit_num),
    .i_ins_num(ins_num), .ctx(ctx_if), .o_ctx_en(ctx_en), .o_ctx_wea(ctx_wea),
    .o_ctx_addr(ctx_addr), .o_ctx_data(ctx_data), .o_state_ena(state_ena),
    .o_state_wea(state_wea), .o_state_addra(state_addra), .o_state_dina(state_dina),
    .o_qea_start(qea_start), .i_qea_complete(qea_complete), .o_busy(busy),
    .o_done(done), .o_err(err), .o_cycle_cnt(cycle_cnt)
  );

  typedef struct { int due; int addr; logic [2*DW-1:0] data; } ctx_exp_t;
  typedef struct { int addr; logic [SWD-1:0] data; } st_exp_t;
  typedef struct { int kind; int cnt; } evt_t;  // kind: 0 err, 1 start, 2 done

  ctx_exp_t ctx_q[$];
  st_exp_t  st_q[$];
  evt_t     evt_q[$];
  int vectors = 0, miscompares = 0, cyc = 0;
  int exp_ins = 0, xfer_n = 0, last_st_cyc = -10, start_cyc = 0;
  bit start_seen = 0, done_seen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [SWD-1:0] act, input logic [SWD-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: output seen with no expectation pending", name);
  endtask

  // Monitor: handshakes create ctx expectations; every DUT output pops one.
  ctx_exp_t ce;
  st_exp_t  se;
  evt_t     ev;
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (ctx_if.valid && ctx_if.ready) begin
        if (xfer_n >= exp_ins) unexpected("ctx_accept");
        else begin
          ctx_q.push_back('{cyc + 1, xfer_n, ctx_if.data});
          xfer_n++;
        end
      end
      if (ctx_en || ctx_wea) begin
        if (ctx_q.size() == 0) unexpected("ctx_write");
        else begin
          ce = ctx_q.pop_front();
          check("ctx_cycle", cyc, ce.due);
          check("ctx_wea", ctx_wea, 1);
          check("ctx_addr", ctx_addr, ce.addr);
          check("ctx_data", ctx_data, ce.data);
        end
      end
      if (state_ena || state_wea) begin
        if (st_q.size() == 0) unexpected("state_write");
        else begin
          se = st_q.pop_front();
          if (se.addr > 0) check("state_contig", cyc, last_st_cyc + 1);
          last_st_cyc = cyc;
          check("state_wea", state_wea, 1);
          check("state_addr", state_addra, se.addr);
          check("state_data", state_dina, se.data);
        end
      end
      if (err) begin
        if (evt_q.size() == 0) unexpected("err_pulse");
        else begin ev = evt_q.pop_front(); check("err_kind", ev.kind, 0); end
      end
      if (qea_start) begin
        if (evt_q.size() == 0) unexpected("qea_start");
        else begin
          ev = evt_q.pop_front();
          check("start_kind", ev.kind, 1);
          check("start_cnt_clear", cycle_cnt, 0);
          check("state_done_before_start", st_q.size(), 0);
          start_seen = 1; start_cyc = cyc;
        end
      end
      if (done) begin
        if (evt_q.size() == 0) unexpected("done_pulse");
        else begin
          ev = evt_q.pop_front();
          check("done_kind", ev.kind, 2);
          check("cycle_cnt", cycle_cnt, ev.cnt);
          check("busy_at_done", busy, 1);
          done_seen = 1;
        end
      end
    end
  end

  task automatic cfg(input int q, input int n);
    @(posedge clk); #1;
    cfg_start = 1'b1; qbit_num = MQW'(q); ins_num = (GW+1)'(n);
    @(posedge clk); #1;
    cfg_start = 1'b0;
  endtask

  // mode 0: back-to-back, 1: valid toggles 1,0,1,0, 2: random valid
  task automatic feed(input int n, input int mode);
    int sent = 0, guard = 0;
    bit tog = 1'b1;
    while (sent < n && guard < 2000) begin
      ctx_if.valid = (mode == 0) ? 1'b1 : (mode == 1) ? tog : 1'($urandom_range(0, 1));
      tog = !tog;
      ctx_if.data = {$urandom, $urandom};
      @(negedge clk);
      if (ctx_if.valid && ctx_if.ready) sent++;
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 2000) unexpected("feed_timeout");
    // one extra offered word right after the last transfer must not be taken
    ctx_if.valid = 1'b1; ctx_if.data = {$urandom, $urandom};
    @(posedge clk); #1;
    ctx_if.valid = 1'b0;
  endtask

  task automatic run_job(input int q, input int n, input int mode, input int d);
    int nw = 1 << (q - 2);
    int guard = 0;
    exp_ins = n; xfer_n = 0; start_seen = 0; done_seen = 0;
    for (int i = 0; i < nw; i++) st_q.push_back('{i, (i == 0) ? WORD0 : '0});
    // completion is only recognised from the second WAIT cycle on
    evt_q.push_back('{1, 0});
    evt_q.push_back('{2, (d < 2) ? 2 : d});
    cfg(q, n);
    if (n > 0) feed(n, mode);
    cfg_start = 1'b1; qbit_num = MQW'(1);  // must be ignored while busy
    while (!(start_seen && cyc >= start_cyc + d) && guard < 5000) begin
      @(posedge clk); #1; guard++;
    end
    if (guard >= 5000) unexpected("start_timeout");
    qea_complete = 1'b1; cfg_start = 1'b0;
    guard = 0;
    while (!done_seen && guard < 200) begin @(negedge clk); guard++; end
    if (guard >= 200) unexpected("done_timeout");
    @(posedge clk); #1;
    qea_complete = 1'b0;
    @(negedge clk);
    check("busy_after_done", busy, 0);
    check("ctx_count", xfer_n, n);
    check("queues_drained", ctx_q.size() + st_q.size() + evt_q.size(), 0);
  endtask

  task automatic bad_cfg(input int q);
    exp_ins = 0; xfer_n = 0;
    evt_q.push_back('{0, 0});
    cfg(q, 3);
    for (int i = 0; i < 4; i++) begin @(negedge clk); check("busy_err", busy, 0); end
    check("err_consumed", evt_q.size(), 0);
  endtask

  task automatic reset_mid();
    int guard = 0;
    exp_ins = 0; xfer_n = 0;
    for (int i = 0; i < 8; i++) st_q.push_back('{i, (i == 0) ? WORD0 : '0});
    evt_q.push_back('{1, 0});
    cfg(5, 0);
    while (!(state_ena && state_addra == SAW'(5)) && guard < 100) begin @(negedge clk); guard++; end
    if (guard >= 100) unexpected("addr5_timeout");
    #2 rst = 1'b1;
    #1;
    check("rst_state_ena", state_ena, 0);
    check("rst_state_addr", state_addra, 0);
    check("rst_busy", busy, 0);
    check("rst_all_outputs", |{ctx_en, ctx_wea, ctx_addr, ctx_data, state_wea, state_dina,
                               qea_start, done, err, cycle_cnt, ctx_if.ready}, 0);
    ctx_q.delete(); st_q.delete(); evt_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    ctx_if.valid = 1'b0; ctx_if.data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_outputs", |{ctx_en, state_ena, state_addra, state_dina, qea_start,
                             done, err, cycle_cnt, ctx_if.ready}, 0);
    @(posedge clk); #1 rst = 1'b0;
    run_job(4, 3, 0, 10);
    run_job(3, 4, 1, 5);
    bad_cfg(1);
    bad_cfg(19);
    bad_cfg(0);
    run_job(2, 0, 0, 1);
    reset_mid();
    run_job(3, 2, 0, 3);
    for (int j = 0; j < 5; j++)
      run_job(int'($urandom_range(2, 6)), int'($urandom_range(0, 6)), 2, int'($urandom_range(1, 20)));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, vectors %0d", vectors);
    $fatal(1);
  end
endmodule
